// File: rtl/wb_buffer_pkg.sv
// Shared register-file constants and the write-buffer entry type.
// Imported by the write buffer, its forwarding matcher and its interface.
package wb_buffer_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int WB_DEPTH   = 4;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

endpackage

// File: rtl/wb_buffer_if.sv
// Producer, register-file write port and read-forwarding signals of the write buffer.
// The slave modport is the buffer itself; master is everything around it.
interface wb_buffer_if
    import wb_buffer_pkg::*;
();

    logic                  inValid;
    logic                  inReady;
    logic [REG_ADDR_W-1:0] inAddr;
    logic [DATA_W-1:0]     inData;

    logic                  wrEn;
    logic [REG_ADDR_W-1:0] wrAddr;
    logic [DATA_W-1:0]     wrData;

    logic [REG_ADDR_W-1:0] rdAddr1;
    logic [REG_ADDR_W-1:0] rdAddr2;
    logic [DATA_W-1:0]     rdData1In;
    logic [DATA_W-1:0]     rdData2In;
    logic [DATA_W-1:0]     rdData1;
    logic [DATA_W-1:0]     rdData2;

    modport slave (
        input  inValid, inAddr, inData,
        input  rdAddr1, rdAddr2, rdData1In, rdData2In,
        output inReady, wrEn, wrAddr, wrData,
        output rdData1, rdData2
    );

    modport master (
        output inValid, inAddr, inData,
        output rdAddr1, rdAddr2, rdData1In, rdData2In,
        input  inReady, wrEn, wrAddr, wrData,
        input  rdData1, rdData2
    );

endinterface

// File: rtl/wb_fwd_match.sv
// Finds the youngest pending write-buffer entry whose address matches rd_addr.
// Entries are scanned oldest to youngest so the last hit wins.
module wb_fwd_match
    import wb_buffer_pkg::*;
#(
    parameter  int DEPTH = WB_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  wb_entry_t [DEPTH-1:0]  entries,
    input  logic [PTR_W-1:0]       head,
    input  logic [CNT_W-1:0]       count,
    input  logic [REG_ADDR_W-1:0]  rd_addr,
    output logic                   hit,
    output logic [DATA_W-1:0]      data
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (entries[idx].addr == rd_addr)) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/wb_buffer.sv
// Register-file write buffer: circular FIFO of pending writes that drains one
// entry per cycle and forwards the youngest pending value to both read ports.
module wb_buffer
    import wb_buffer_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    wb_buffer_if.slave             bus,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t [DEPTH-1:0] mem;
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic                  push;
    logic                  pop;
    logic                  hit1;
    logic                  hit2;
    logic [DATA_W-1:0]     fwd1;
    logic [DATA_W-1:0]     fwd2;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // Writes to x0 are accepted on the handshake but never stored.
    assign bus.inReady = !full;
    assign push        = bus.inValid && !full && (bus.inAddr != '0);
    assign pop         = !empty;

    assign bus.wrEn   = !empty;
    assign bus.wrAddr = mem[head].addr;
    assign bus.wrData = mem[head].data;

    // Storage is data only; an empty buffer masks whatever it holds.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= '{addr: bus.inAddr, data: bus.inData};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    wb_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
        .entries (mem),
        .head    (head),
        .count   (count),
        .rd_addr (bus.rdAddr1),
        .hit     (hit1),
        .data    (fwd1)
    );

    wb_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
        .entries (mem),
        .head    (head),
        .count   (count),
        .rd_addr (bus.rdAddr2),
        .hit     (hit2),
        .data    (fwd2)
    );

    always_comb begin
        bus.rdData1 = bus.rdData1In;
        bus.rdData2 = bus.rdData2In;
        if (bus.rdAddr1 == '0)  bus.rdData1 = '0;
        else if (hit1)          bus.rdData1 = fwd1;
        if (bus.rdAddr2 == '0)  bus.rdData2 = '0;
        else if (hit2)          bus.rdData2 = fwd2;
    end

endmodule

// File: tb/tb_wb_buffer.sv
// Directed bench for wb_buffer: a queue model of pending writes is checked
// against the DUT every cycle, plus literal expectations for key scenarios.
module tb_wb_buffer;

    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] count;
    logic       full;
    logic       empty;

    wb_buffer_if bus();

    wb_buffer #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    ent_t q[$];
    ent_t model_log[$];
    ent_t dut_log[$];
    ent_t pend;
    logic pend_v = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input logic [31:0] raw);
        if (a == 5'd0) return 32'd0;
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].addr == a) return q[i].data;
        return raw;
    endfunction

    // Model: pending writes are a queue; head drains every edge, accepted non-x0 input appends.
    always @(posedge clk) begin
        if (rst) begin
            bit ready;
            ready = (q.size() < DEPTH);
            if (pend_v) dut_log.push_back(pend);
            pend_v = 1'b0;
            if (q.size() != 0) model_log.push_back(q.pop_front());
            if (bus.inValid && ready && bus.inAddr != 5'd0)
                q.push_back('{addr: bus.inAddr, data: bus.inData});
        end
    end

    always @(negedge rst) begin
        q.delete();
        pend_v = 1'b0;
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("wrEn", {31'd0, bus.wrEn}, {31'd0, q.size() != 0});
        if (q.size() != 0) begin
            check("wrAddr", {27'd0, bus.wrAddr}, {27'd0, q[0].addr});
            check("wrData", bus.wrData, q[0].data);
        end
        check("count", {29'd0, count}, q.size());
        check("full", {31'd0, full}, {31'd0, q.size() == DEPTH});
        check("empty", {31'd0, empty}, {31'd0, q.size() == 0});
        check("inReady", {31'd0, bus.inReady}, {31'd0, q.size() != DEPTH});
        check("rdData1", bus.rdData1, exp_rd(bus.rdAddr1, bus.rdData1In));
        check("rdData2", bus.rdData2, exp_rd(bus.rdAddr2, bus.rdData2In));
        pend_v = bus.wrEn && rst;
        pend   = '{addr: bus.wrAddr, data: bus.wrData};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.inValid = v;
        bus.inAddr  = a;
        bus.inData  = d;
    endtask

    initial begin
        set_in(1'b0, 5'd0, 32'd0);
        bus.rdAddr1   = 5'd0;
        bus.rdAddr2   = 5'd0;
        bus.rdData1In = 32'd0;
        bus.rdData2In = 32'd0;
        #1;
        check("rst_inReady", {31'd0, bus.inReady}, 32'd1);
        check("rst_wrEn", {31'd0, bus.wrEn}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_count", {29'd0, count}, 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Single write and its one-cycle latency.
        set_in(1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        set_in(1'b0, 5'd0, 32'd0);
        check("single_wrEn", {31'd0, bus.wrEn}, 32'd1);
        check("single_wrAddr", {27'd0, bus.wrAddr}, 32'd5);
        check("single_wrData", bus.wrData, 32'hDEADBEEF);
        tick();
        check("single_empty", {31'd0, empty}, 32'd1);
        check("single_wrEn_off", {31'd0, bus.wrEn}, 32'd0);

        // Back-to-back x1..x4 drain in order while occupancy stays at one.
        for (int i = 1; i <= 4; i++) begin
            set_in(1'b1, 5'(i), 32'hB0 + 32'(i));
            tick();
            check("fill_wrAddr", {27'd0, bus.wrAddr}, 32'(i));
            check("fill_wrData", bus.wrData, 32'hB0 + 32'(i));
            check("fill_count", {29'd0, count}, 32'd1);
            check("fill_inReady", {31'd0, bus.inReady}, 32'd1);
        end
        set_in(1'b0, 5'd0, 32'd0);
        tick();

        // Forwarding: youngest x7 value wins, other port passes raw data.
        bus.rdAddr1   = 5'd7;
        bus.rdData1In = 32'h0;
        bus.rdAddr2   = 5'd3;
        bus.rdData2In = 32'h0000CAFE;
        set_in(1'b1, 5'd7, 32'h11);
        tick();
        check("fwd_first", bus.rdData1, 32'h11);
        set_in(1'b1, 5'd7, 32'h22);
        tick();
        set_in(1'b0, 5'd0, 32'd0);
        check("fwd_youngest", bus.rdData1, 32'h22);
        check("fwd_miss", bus.rdData2, 32'h0000CAFE);
        tick();
        check("fwd_drained", bus.rdData1, 32'h0);

        // In-flight input is not visible before acceptance.
        bus.rdAddr1   = 5'd9;
        bus.rdData1In = 32'h55;
        set_in(1'b1, 5'd9, 32'hAA);
        #1;
        check("no_inflight_fwd", bus.rdData1, 32'h55);
        tick();
        set_in(1'b0, 5'd0, 32'd0);
        check("accepted_fwd", bus.rdData1, 32'hAA);
        tick();

        // x0 writes are dropped and x0 reads are zero.
        bus.rdAddr1   = 5'd0;
        bus.rdData1In = 32'h12345678;
        set_in(1'b1, 5'd0, 32'hFFFFFFFF);
        tick();
        set_in(1'b0, 5'd0, 32'd0);
        check("x0_count", {29'd0, count}, 32'd0);
        check("x0_wrEn", {31'd0, bus.wrEn}, 32'd0);
        check("x0_rd", bus.rdData1, 32'd0);
        tick();

        // Twenty back-to-back pushes across several pointer wraps.
        for (int i = 0; i < 20; i++) begin
            set_in(1'b1, 5'((i % 31) + 1), 32'h1000 + 32'(i));
            tick();
            check("wrap_count", {29'd0, count}, 32'd1);
            check("wrap_wrAddr", {27'd0, bus.wrAddr}, 32'((i % 31) + 1));
            check("wrap_wrData", bus.wrData, 32'h1000 + 32'(i));
        end
        set_in(1'b0, 5'd0, 32'd0);
        tick();

        // Asynchronous reset while writes are pending.
        for (int i = 10; i <= 12; i++) begin
            set_in(1'b1, 5'(i), 32'h700 + 32'(i));
            tick();
        end
        set_in(1'b0, 5'd0, 32'd0);
        #2;
        rst = 1'b0;
        #1;
        check("arst_wrEn", {31'd0, bus.wrEn}, 32'd0);
        check("arst_count", {29'd0, count}, 32'd0);
        check("arst_empty", {31'd0, empty}, 32'd1);
        check("arst_inReady", {31'd0, bus.inReady}, 32'd1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("post_rst_wrEn", {31'd0, bus.wrEn}, 32'd0);
        set_in(1'b1, 5'd13, 32'h77);
        tick();
        set_in(1'b0, 5'd0, 32'd0);
        check("resume_wrEn", {31'd0, bus.wrEn}, 32'd1);
        check("resume_wrAddr", {27'd0, bus.wrAddr}, 32'd13);
        tick();
        tick();

        // Committed write stream must equal the model's drained stream.
        check("log_size", dut_log.size(), model_log.size());
        for (int i = 0; i < model_log.size() && i < dut_log.size(); i++) begin
            check("log_addr", {27'd0, dut_log[i].addr}, {27'd0, model_log[i].addr});
            check("log_data", dut_log[i].data, model_log[i].data);
        end
        if (model_log.size() > 0)
            check("log_first", model_log[0].data, 32'hDEADBEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
